// File: rtl/immext_pipe_if.sv
// immext_pipe_if: valid/ready bundle carrying instruction words in and extended immediates out
//   Parameters: XLEN (immediate width, 32 or 64), TAGW (sideband tag width)
//   Input side : InValid, InReady, Instr[31:0], ImmSrc[2:0], InTag[TAGW-1:0]
//   Output side: OutValid, OutReady, ImmExt[XLEN-1:0], OutTag[TAGW-1:0], ImmIllegal
//   modport slave  : the extender itself
//   modport master : the decode/execute environment around it
interface immext_pipe_if #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
);
    logic            InValid;
    logic            InReady;
    logic [31:0]     Instr;
    logic [2:0]      ImmSrc;
    logic [TAGW-1:0] InTag;
    logic            OutValid;
    logic            OutReady;
    logic [XLEN-1:0] ImmExt;
    logic [TAGW-1:0] OutTag;
    logic            ImmIllegal;

    modport slave (
        input  InValid, Instr, ImmSrc, InTag, OutReady,
        output InReady, OutValid, ImmExt, OutTag, ImmIllegal
    );

    modport master (
        output InValid, Instr, ImmSrc, InTag, OutReady,
        input  InReady, OutValid, ImmExt, OutTag, ImmIllegal
    );
endinterface

// File: rtl/immext_pipe.sv
// immext_pipe: pipelined immediate extender with a 2-entry skid buffer between decode and execute
//   Ports: clk (rising edge), reset (synchronous, active-high), bus (immext_pipe_if.slave)
//   Input handshake : bus.InValid/InReady with Instr, ImmSrc, InTag
//   Output handshake: bus.OutValid/OutReady with ImmExt, OutTag, ImmIllegal
//   Formats: 000 I, 001 S, 010 B, 011 J, 100 U, 101 CI / 110 CJ (only with IMMEXT_RVC_EN), 111 reserved
//   Macro IMMEXT_RVC_EN: when defined, compressed CI/CJ immediates are decoded; otherwise 101/110 are illegal
module immext_pipe #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic          clk,
    input  logic          reset,
    immext_pipe_if.slave  bus
);
    localparam int EW = XLEN + TAGW + 1;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [EW-1:0]   r_mem [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [31:0]     w_ins;
    logic            w_s;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic            w_push;
    logic            w_pop;
    logic            w_unused;

    assign w_ins    = bus.Instr;
    assign w_s      = w_ins[31];
    assign w_unused = ^w_ins[6:0];

    // Immediate is formed combinationally and captured when the entry is written
    always_comb begin
        w_imm     = '0;
        w_illegal = 1'b0;
        case (bus.ImmSrc)
            3'b000:  w_imm = {{(XLEN-12){w_s}}, w_ins[31:20]};
            3'b001:  w_imm = {{(XLEN-12){w_s}}, w_ins[31:25], w_ins[11:7]};
            3'b010:  w_imm = {{(XLEN-13){w_s}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
            3'b011:  w_imm = {{(XLEN-21){w_s}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
            3'b100:  w_imm = {{(XLEN-31){w_s}}, w_ins[30:12], 12'b0};
`ifdef IMMEXT_RVC_EN
            3'b101:  w_imm = {{(XLEN-6){w_ins[12]}}, w_ins[12], w_ins[6:2]};
            3'b110:  w_imm = {{(XLEN-12){w_ins[12]}}, w_ins[12], w_ins[8], w_ins[10:9], w_ins[6],
                              w_ins[7], w_ins[2], w_ins[11], w_ins[5:3], 1'b0};
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    // Handshakes use the registered ready/valid, so FULL ignores input and EMPTY ignores OutReady
    assign w_push = bus.InValid & r_in_ready;
    assign w_pop  = r_out_valid & bus.OutReady;

    always_comb begin
        w_next = (r_state == EMPTY) ? (w_push ? ONE : EMPTY) :
                 (r_state == ONE)   ? ((w_push && !w_pop) ? FULL : (w_pop && !w_push) ? EMPTY : ONE) :
                                      (w_pop ? ONE : FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_mem[0]    <= '0;
            r_mem[1]    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_imm, bus.InTag, w_illegal};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_state     <= w_next;
            r_in_ready  <= (w_next != FULL);
            r_out_valid <= (w_next != EMPTY);
        end
    end

    // Reset gating keeps upstream from handing over words that the reset edge would discard
    assign bus.InReady  = r_in_ready & ~reset;
    assign bus.OutValid = r_out_valid;
    assign {bus.ImmExt, bus.OutTag, bus.ImmIllegal} = r_mem[r_rd_ptr];
endmodule

// File: tb/tb_immext_pipe.sv
// tb_immext_pipe: directed vectors against XLEN=32 and XLEN=64 instances with a queue-based reference model
module tb_immext_pipe;
`ifdef IMMEXT_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [2:0]  src;
    logic [4:0]  tag;
    int          vectors = 0;
    int          errs = 0;
    exp_t        q[$];

    logic [31:0] st_ins [4] = '{32'hFFF00093, 32'h00512423, 32'hFE000EE3, 32'h123450B7};
    logic [2:0]  st_src [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    logic [31:0] st_exp [4] = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFFC, 32'h12345000};

    immext_pipe_if #(.XLEN(32), .TAGW(5)) b32 ();
    immext_pipe_if #(.XLEN(64), .TAGW(5)) b64 ();

    assign b32.InValid  = in_valid;
    assign b32.Instr    = instr;
    assign b32.ImmSrc   = src;
    assign b32.InTag    = tag;
    assign b32.OutReady = out_ready;
    assign b64.InValid  = in_valid;
    assign b64.Instr    = instr;
    assign b64.ImmSrc   = src;
    assign b64.InTag    = tag;
    assign b64.OutReady = out_ready;

    immext_pipe #(.XLEN(32), .TAGW(5)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
    immext_pipe #(.XLEN(64), .TAGW(5)) dut64 (.clk(clk), .reset(reset), .bus(b64.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: arithmetic on the sign-extended word, independent of bit-field concatenation
    function automatic logic [63:0] ref_imm(input logic [31:0] x, input logic [2:0] f);
        longint s;
        s = longint'($signed(x));
        case (f)
            3'd0: return s >>> 20;
            3'd1: return ((s >>> 25) <<< 5) | longint'(x[11:7]);
            3'd2: return ((s >>> 31) <<< 12) | (longint'(x[7]) << 11) | (longint'(x[30:25]) << 5)
                         | (longint'(x[11:8]) << 1);
            3'd3: return ((s >>> 31) <<< 20) | (longint'(x[19:12]) << 12) | (longint'(x[20]) << 11)
                         | (longint'(x[30:21]) << 1);
            3'd4: return (s >>> 12) <<< 12;
            3'd5: return RVC ? longint'(x[6:2]) - 32 * longint'(x[12]) : 64'd0;
            3'd6: return RVC ? (longint'(x[11]) << 4) + (longint'(x[10:9]) << 8) + (longint'(x[8]) << 10)
                         + (longint'(x[7]) << 6) + (longint'(x[6]) << 7) + (longint'(x[5:3]) << 1)
                         + (longint'(x[2]) << 5) - 2048 * longint'(x[12]) : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic ref_ill(input logic [2:0] f);
        return (f == 3'd7) || ((f == 3'd5 || f == 3'd6) && !RVC);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare process: every negedge check both DUTs against the model, then advance it
    initial begin
        bit push, pop;
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("in_ready32", b32.InReady, !reset && q.size() < 2);
            chk("in_ready64", b64.InReady, !reset && q.size() < 2);
            chk("out_valid32", b32.OutValid, q.size() != 0);
            chk("out_valid64", b64.OutValid, q.size() != 0);
            if (q.size() != 0) begin
                chk("imm32", b32.ImmExt, q[0].imm & 64'hFFFFFFFF);
                chk("imm64", b64.ImmExt, q[0].imm);
                chk("tag32", b32.OutTag, q[0].tag);
                chk("tag64", b64.OutTag, q[0].tag);
                chk("ill32", b32.ImmIllegal, q[0].ill);
                chk("ill64", b64.ImmIllegal, q[0].ill);
            end
            if (reset) q.delete();
            else begin
                pop  = (q.size() != 0) && out_ready;
                push = in_valid && (q.size() < 2);
                if (pop) void'(q.pop_front());
                if (push) begin
                    e.imm = ref_imm(instr, src);
                    e.tag = tag;
                    e.ill = ref_ill(src);
                    q.push_back(e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; instr = '0; src = '0; tag = '0;
        chk("pin_I", ref_imm(32'hFFF00093, 3'd0), 64'hFFFFFFFFFFFFFFFF);
        chk("pin_S", ref_imm(32'h00512423, 3'd1), 64'h0000000000000008);
        chk("pin_B", ref_imm(32'hFE000EE3, 3'd2), 64'hFFFFFFFFFFFFFFFC);
        chk("pin_U", ref_imm(32'h123450B7, 3'd4), 64'h0000000012345000);
        chk("pin_U64", ref_imm(32'h800000B7, 3'd4), 64'hFFFFFFFF80000000);
        chk("pin_J", ref_imm(32'hFF9FF06F, 3'd3), 64'hFFFFFFFFFFFFFFF8);
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", b32.OutValid, 1'b0);
        chk("reset_imm", b32.ImmExt, 64'd0);
        step();
        // back-to-back stream, one result per cycle
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                in_valid = 1'b1; instr = st_ins[i]; src = st_src[i]; tag = 5'(i + 1);
            end else in_valid = 1'b0;
            @(negedge clk);
            if (i > 0) begin
                chk("stream_imm", b32.ImmExt, 64'(st_exp[i-1]));
                chk("stream_tag", b32.OutTag, 64'(i));
                chk("stream_valid", b32.OutValid, 1'b1);
            end
            step();
        end
        // XLEN=64 U and J
        in_valid = 1'b1; instr = 32'h800000B7; src = 3'd4; tag = 5'd5;
        step();
        instr = 32'hFF9FF06F; src = 3'd3; tag = 5'd6;
        @(negedge clk);
        chk("u64_imm", b64.ImmExt, 64'hFFFFFFFF80000000);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("j64_imm", b64.ImmExt, 64'hFFFFFFFFFFFFFFF8);
        chk("j64_tag", b64.OutTag, 64'd6);
        step();
        // backpressure: third push must wait
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'hFFF00093; src = 3'd0; tag = 5'd8;
        step();
        instr = 32'h00512423; src = 3'd1; tag = 5'd9;
        step();
        instr = 32'h123450B7; src = 3'd4; tag = 5'd10;
        @(negedge clk);
        chk("bp_full_ready", b32.InReady, 1'b0);
        chk("bp_head_tag", b32.OutTag, 64'd8);
        step(); step();
        @(negedge clk);
        chk("bp_hold_tag", b32.OutTag, 64'd8);
        chk("bp_hold_imm", b32.ImmExt, 64'hFFFFFFFF);
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_ready_after_pop", b32.InReady, 1'b1);
        chk("bp_second_tag", b32.OutTag, 64'd9);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_third_tag", b32.OutTag, 64'd10);
        chk("bp_third_imm", b32.ImmExt, 64'h12345000);
        step();
        // reserved and compressed formats
        in_valid = 1'b1; instr = 32'hFFFFFFFF; src = 3'd7; tag = 5'd7;
        step();
        instr = 32'h0000107C; src = 3'd5; tag = 5'd11;
        @(negedge clk);
        chk("rsv_imm", b32.ImmExt, 64'd0);
        chk("rsv_ill", b32.ImmIllegal, 1'b1);
        chk("rsv_tag", b32.OutTag, 64'd7);
        chk("rsv_imm64", b64.ImmExt, 64'd0);
        step();
        instr = 32'h0000BFFD; src = 3'd6; tag = 5'd12;
        @(negedge clk);
        chk("ci_imm", b32.ImmExt, RVC ? 64'hFFFFFFFF : 64'd0);
        chk("ci_ill", b32.ImmIllegal, !RVC);
        chk("ci_imm64", b64.ImmExt, RVC ? 64'hFFFFFFFFFFFFFFFF : 64'd0);
        step();
        in_valid = 1'b0;
        step();
        // reset with a full buffer
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h123450B7; src = 3'd4; tag = 5'd13;
        step();
        instr = 32'hFE000EE3; src = 3'd2; tag = 5'd14;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_full", b32.InReady, 1'b0);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_low", b32.InReady, 1'b0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", b32.OutValid, 1'b0);
        chk("rst_imm", b32.ImmExt, 64'd0);
        chk("rst_imm64", b64.ImmExt, 64'd0);
        chk("rst_tag", b32.OutTag, 64'd0);
        chk("rst_ill", b32.ImmIllegal, 1'b0);
        chk("rst_in_ready", b32.InReady, 1'b1);
        step();
        in_valid = 1'b1; out_ready = 1'b1; instr = 32'h00512423; src = 3'd1; tag = 5'd15;
        @(negedge clk);
        chk("post_rst_not_yet", b32.OutValid, 1'b0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", b32.OutValid, 1'b1);
        chk("post_rst_imm", b32.ImmExt, 64'h8);
        chk("post_rst_tag", b32.OutTag, 64'd15);
        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
